// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Port 0 is the core, port 1 the loader/debug port. Each access walks
// IDLE -> ISSUE -> DONE, so a request granted at one edge is acknowledged
// two cycles later and back-to-back accesses take three cycles each.
module mem_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               gsel_q, gsel_d;
    logic               rd_q, rd_d;
    logic [1:0]         ack_q, ack_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [WIDTH-1:0]   mem_adr_q, mem_adr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               grant;

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gsel_d       = gsel_q;
        rd_d         = rd_q;
        ack_d        = 2'b00;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        // On a tie the port that did not win last time goes next.
        grant        = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (req0 || req1) begin
                    gsel_d       = grant;
                    last_grant_d = grant;
                    mem_en_d     = 1'b1;
                    mem_we_d     = grant ? we1 : we0;
                    mem_adr_d    = grant ? adr1 : adr0;
                    mem_wdata_d  = grant ? wdata1 : wdata0;
                    rd_d         = ~(grant ? we1 : we0);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // The memory samples the command at the edge leaving ISSUE.
                mem_en_d      = 1'b0;
                mem_we_d      = 1'b0;
                ack_d[gsel_q] = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                // Hold the read word so it persists after the ack cycle.
                if (rd_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gsel_q       <= 1'b0;
            rd_q         <= 1'b0;
            ack_q        <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gsel_q       <= gsel_d;
            rd_q         <= rd_d;
            ack_q        <= ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    // mem_rdata is the memory's output register, so forwarding it during
    // DONE keeps rdata register-driven while making it valid with the ack.
    assign rdata     = (state_q == DONE && rd_q) ? mem_rdata : rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port code/data memory between the MIPS core (port 0) and a program loader/debug port (port 1).
- Sits between the requesters and the memory instance inside the processor/memory top level.
- Uses a request/acknowledge handshake per port, round-robin arbitration and a registered three-state sequencer.
- Accounts for the memory's one-cycle synchronous read latency.

Parameters:
- WIDTH, 8, data and address width in bits (matches core datapath).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  core request; held high until ack0.
- we0  input  1  core write enable (1 = write, 0 = read); stable while req0 is high.
- adr0  input  WIDTH  core address; stable while req0 is high.
- wdata0  input  WIDTH  core write data.
- ack0  output  1  one-cycle completion pulse to the core.
- req1  input  1  loader request; held high until ack1.
- we1  input  1  loader write enable.
- adr1  input  WIDTH  loader address.
- wdata1  input  WIDTH  loader write data.
- ack1  output  1  one-cycle completion pulse to the loader.
- rdata  output  WIDTH  read data, shared by both ports; valid in the ack cycle of a read.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_adr  output  WIDTH  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory read data; valid the cycle after mem_en=1, mem_we=0.

Behaviour:
- States: IDLE, ISSUE, DONE. All outputs are registered.
- Reset values (checked on the cycle after reset is sampled high):
  - state = IDLE; ack0 = ack1 = 0; mem_en = mem_we = 0; mem_adr = mem_wdata = 0; rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- IDLE:
  - No request: stay in IDLE; mem_en = 0.
  - Exactly one req high: grant that port.
  - Both high: grant the port not equal to last_grant.
  - On grant: latch we/adr/wdata of the granted port into mem_we/mem_adr/mem_wdata, set mem_en = 1, record gsel, set last_grant = gsel, go to ISSUE.
- ISSUE:
  - mem_en, mem_we, mem_adr and mem_wdata are held for exactly this one cycle.
  - Next cycle: mem_en = 0, mem_we = 0; go to DONE.
- DONE:
  - ack<gsel> = 1 for exactly one cycle.
  - Read: rdata is captured from mem_rdata (the value addressed in ISSUE) and is valid in this cycle.
  - Write: rdata is unchanged.
  - Next state is IDLE.
- Latency and throughput:
  - Request sampled in IDLE at edge N: ISSUE in cycle N+1, ack in cycle N+2.
  - Minimum period per access is 3 cycles.
- Handshake rules:
  - A requester drops req (or presents a new transaction) at the edge that ends its ack cycle.
  - req still high in the following IDLE is treated as a new transaction.
  - Changing we/adr/wdata while req is high and before the ISSUE edge is illegal; the arbiter samples them only at the IDLE grant edge.
- Non-granted requester: its req is ignored until the arbiter returns to IDLE. No ack is issued to it and no transaction is dropped.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1,… Neither port waits more than one access.
- Simultaneous events: ack and grant never share a cycle, and at most one ack is high in any cycle.
- rdata persists until the next read's DONE cycle.
- Reset mid-operation:
  - Returns to IDLE next cycle; any pending ack is suppressed.
  - A write already driven in ISSUE may have completed in memory; no retry is made.
- The arbiter performs no address-range checking; addresses pass through unmodified at WIDTH bits.

Test Plan:
- Reset then idle: assert reset for 2 cycles with req0 = req1 = 0. Required: all outputs 0 and mem_en stays 0 for 10 cycles.
- Core read: preload mem[0x12] = 0xA5; req0 = 1, we0 = 0, adr0 = 0x12.
  - Cycle +1: mem_en = 1, mem_we = 0, mem_adr = 0x12.
  - Cycle +2: ack0 = 1 and rdata = 0xA5; ack1 stays 0.
- Loader write then core read-back: req1 writes 0x3C to adr 0x40.
  - ISSUE: mem_we = 1, mem_wdata = 0x3C; ack1 pulses 2 cycles after request.
  - Core then reads 0x40: rdata = 0x3C with ack0.
- Simultaneous requests after reset: req0 and req1 held high for 4 transactions each.
  - Grant order 0,1,0,1,… with acks every 3 cycles.
  - Each port receives exactly 4 acks, never both in the same cycle.
- Write preserves rdata: read adr 0x05 (returns 0x77), then write 0x99 to 0x06. Required: rdata stays 0x77 through the write's ack.
- Reset in ISSUE: req0 read of 0x12, reset asserted during the ISSUE cycle.
  - No ack0 pulse; state IDLE, mem_en = 0 after reset.
  - The re-issued request completes normally with rdata = 0xA5.
